// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor. Computes diff = a - b over WIDTH cycles, LSB first,
//   using a single full-subtractor cell and a registered borrow. A start/busy/
//   done handshake controls it, and the result holds until the next accepted
//   start completes.
//
// Parameters
//   WIDTH     operand / difference width in bits (>= 2)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request; sampled only in IDLE or DONE
//   a, b      minuend / subtrahend, captured on the accepted start
//   busy      high while the serial cell is running
//   done      one-cycle pulse; diff/borrow valid from this cycle on
//   diff      (a - b) mod 2^WIDTH
//   borrow    1 when a < b (unsigned)
//   overflow  signed overflow flag (only with SERSUB_OVERFLOW_EN defined)
//
// Optional feature macro: SERSUB_OVERFLOW_EN
//
// State table
//   IDLE | waiting for start, result held
//   RUN  | one bit per cycle through the subtractor cell
//   DONE | result just updated, done pulse; start accepted here too
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             br_q,      br_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic             borrow_q,  borrow_d;
`ifdef SERSUB_OVERFLOW_EN
  // Operand sign bits are shifted out of a_sh/b_sh, so keep them separately.
  logic             a_msb_q,   a_msb_d;
  logic             b_msb_q,   b_msb_d;
  logic             ovf_q,     ovf_d;
`endif

  logic x, y, d_bit, br_next;

  always_comb begin
    x       = a_sh_q[0];
    y       = b_sh_q[0];
    d_bit   = x ^ y ^ br_q;
    br_next = (~x & y) | (~x & br_q) | (y & br_q);

    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    ovf_d     = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERSUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = {d_bit, diff_sh_q[WIDTH-1:1]};
        br_d      = br_next;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Last bit: publish the result so it is visible in the DONE cycle.
          state_d  = DONE;
          diff_d   = diff_sh_d;
          borrow_d = br_next;
`ifdef SERSUB_OVERFLOW_EN
          // d_bit is the sign bit of the difference here.
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      br_q      <= br_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
`ifdef SERSUB_OVERFLOW_EN
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=4). A vector table drives
//   single operations; hand-written sequences cover ignored start, back-to-back
//   start in the done cycle, and reset mid-run. Expected results are queued
//   when a start is accepted and compared by a monitor on each done pulse.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERSUB_OVERFLOW_EN
  logic         overflow;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
`ifdef SERSUB_OVERFLOW_EN
    .overflow (overflow),
`endif
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Step into the next cycle and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic br, input logic ov);
    exp_t e;
    e.diff = d; e.borrow = br; e.ovf = ov;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (done && busy) chk("done_busy_overlap", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_diff", int'(diff), int'(e.diff));
          chk("sb_borrow", int'(borrow), int'(e.borrow));
`ifdef SERSUB_OVERFLOW_EN
          chk("sb_overflow", int'(overflow), int'(e.ovf));
`endif
        end
      end
    end
  end

  vec_t vecs[8];
  logic [W-1:0] prev_diff;

  initial begin
    vecs[0] = '{a:4'd7,  b:4'd3,  diff:4'd4,  borrow:1'b0, ovf:1'b0};
    vecs[1] = '{a:4'd3,  b:4'd7,  diff:4'd12, borrow:1'b1, ovf:1'b0};
    vecs[2] = '{a:4'd0,  b:4'd0,  diff:4'd0,  borrow:1'b0, ovf:1'b0};
    vecs[3] = '{a:4'd7,  b:4'd8,  diff:4'd15, borrow:1'b1, ovf:1'b1};
    vecs[4] = '{a:4'd5,  b:4'd2,  diff:4'd3,  borrow:1'b0, ovf:1'b0};
    vecs[5] = '{a:4'd15, b:4'd1,  diff:4'd14, borrow:1'b0, ovf:1'b0};
    vecs[6] = '{a:4'd0,  b:4'd15, diff:4'd1,  borrow:1'b1, ovf:1'b0};
    vecs[7] = '{a:4'd8,  b:4'd1,  diff:4'd7,  borrow:1'b0, ovf:1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borrow", int'(borrow), 0);
`ifdef SERSUB_OVERFLOW_EN
    chk("rst_overflow", int'(overflow), 0);
`endif
    reset = 1'b0;
    tick();

    // Table-driven single operations with full latency checks.
    prev_diff = '0;
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; start = 1'b1;
      push(vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
      tick();
      start = 1'b0; a = 4'hx; b = 4'hx;
      for (int c = 1; c <= W; c++) begin
        chk($sformatf("v%0d_busy_c%0d", i, c), int'(busy), 1);
        chk($sformatf("v%0d_done_c%0d", i, c), int'(done), 0);
        chk($sformatf("v%0d_hold_c%0d", i, c), int'(diff), int'(prev_diff));
        if (c < W) tick();
      end
      tick();
      chk($sformatf("v%0d_done", i), int'(done), 1);
      chk($sformatf("v%0d_busy_off", i), int'(busy), 0);
      tick();
      chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_result_held", i), int'(diff), int'(vecs[i].diff));
      prev_diff = vecs[i].diff;
    end

    // Start while busy is ignored.
    a = 4'd9; b = 4'd4; start = 1'b1;
    push(4'd5, 1'b0, 1'b1);
    tick(); start = 1'b0;                    // cycle 1
    tick();                                  // cycle 2
    a = 4'd1; b = 4'd1; start = 1'b1;
    tick(); start = 1'b0;                    // cycle 3
    tick(); tick();                          // cycle 5
    chk("ign_done", int'(done), 1);
    chk("ign_diff", int'(diff), 5);

    // Back-to-back: start in the done cycle.
    a = 4'd2; b = 4'd6; start = 1'b1;
    push(4'd12, 1'b1, 1'b0);
    tick(); start = 1'b0;                    // cycle 6
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_hold", int'(diff), 5);
    tick(); tick(); tick(); tick();          // cycle 10
    chk("b2b_done", int'(done), 1);
    chk("b2b_diff", int'(diff), 12);
    tick(); tick();

    // Reset mid-run aborts without a done pulse.
    a = 4'd6; b = 4'd1; start = 1'b1;
    tick(); start = 1'b0;                    // cycle 1
    tick();                                  // cycle 2
    reset = 1'b1;
    tick();                                  // cycle 3
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_diff", int'(diff), 0);
    chk("mrst_borrow", int'(borrow), 0);
    chk("mrst_done", int'(done), 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) tick();      // monitor flags any stray done
    a = 4'd10; b = 4'd3; start = 1'b1;
    push(4'd7, 1'b0, 1'b1);
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("post_rst_done", int'(done), 1);
    chk("post_rst_diff", int'(diff), 7);
    tick(); tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
